// File: rtl/axi4_stream_upsize_gbx_pkg.sv
// Package for the AXI4-Stream gearbox family (upsizer now, downsizer later).
// Contents:
//   tuser_mode_t   - how the wide beat's tuser is built from its narrow lanes
//   lane_ptr_width - width of the lane pointer for a given beat ratio
package axi4_stream_gbx_pkg;

    typedef enum logic {
        TUSER_FIRST = 1'b0,
        TUSER_OR    = 1'b1
    } tuser_mode_t;

    // Never return zero so the pointer stays a legal vector.
    function automatic int lane_ptr_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axi4_stream_upsize_gbx_if.sv
// AXI4-Stream interface shared by the narrow and wide sides of the gearbox.
// Parameters: DATA_BYTES, USER_W, ID_W, DEST_W.
// Modports:
//   master - drives tvalid/tdata/tkeep/tstrb/tuser/tid/tdest/tlast, samples tready
//   slave  - samples the payload, drives tready
interface axi4_stream_if #(
    parameter int DATA_BYTES = 2,
    parameter int USER_W     = 1,
    parameter int ID_W       = 1,
    parameter int DEST_W     = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic [USER_W-1:0]       tuser;
    logic [ID_W-1:0]         tid;
    logic [DEST_W-1:0]       tdest;
    logic                    tlast;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tuser, tid, tdest, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tuser, tid, tdest, tlast,
        output tready
    );
endinterface

// File: rtl/axi4_stream_upsize_gbx.sv
// AXI4-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// Partial words are flushed on tlast or when tid/tdest changes; unused lanes
// are zero-filled. Full input throughput while the sink stays ready.
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset
//   pkt_i    - narrow stream in  (IN_BYTES data bytes)
//   pkt_o    - wide stream out   (IN_BYTES*RATIO data bytes)
module axi4_stream_upsize_gbx
    import axi4_stream_gbx_pkg::*;
#(
    parameter int          IN_BYTES    = 2,
    parameter int          RATIO       = 4,
    parameter int          TUSER_WIDTH = 1,
    parameter int          TID_WIDTH   = 1,
    parameter int          TDEST_WIDTH = 1,
    parameter tuser_mode_t TUSER_MODE  = TUSER_FIRST
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int                LANE_W    = IN_BYTES * 8;
    localparam int                PTR_W     = lane_ptr_width(RATIO);
    localparam logic [PTR_W-1:0]  LAST_LANE = PTR_W'(RATIO - 1);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("axi4_stream_upsize_gbx: RATIO must be a power of two >= 2");
    end

    logic [PTR_W-1:0] ins_pos;
    logic             stream_change;
    logic             flush_req;
    logic             in_hs;
    logic             out_hs;
    logic             word_done;
    int               lane_base;

    // A partial word always has pkt_o.tvalid low (a completed word resets
    // ins_pos), so stream_change alone can gate tready without looking at
    // pkt_i.tvalid.
    always_comb begin
        stream_change = (ins_pos != '0) &&
                        ((pkt_i.tid != pkt_o.tid) || (pkt_i.tdest != pkt_o.tdest));
        flush_req     = pkt_i.tvalid && stream_change && !pkt_o.tvalid;
        pkt_i.tready  = (!pkt_o.tvalid || pkt_o.tready) && !stream_change;
        in_hs         = pkt_i.tvalid && pkt_i.tready;
        out_hs        = pkt_o.tvalid && pkt_o.tready;
        word_done     = in_hs && ((ins_pos == LAST_LANE) || pkt_i.tlast);
        lane_base     = int'(ins_pos);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_o.tvalid <= 1'b0;
            ins_pos      <= '0;
        end else if (flush_req) begin
            pkt_o.tvalid <= 1'b1;
            ins_pos      <= '0;
        end else if (in_hs) begin
            pkt_o.tvalid <= word_done;
            ins_pos      <= word_done ? '0 : ins_pos + 1'b1;
        end else if (out_hs) begin
            pkt_o.tvalid <= 1'b0;
        end
    end

    // The output register is also the accumulator; it only changes when a
    // beat is accepted, which the tready rule forbids during an output stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_o.tdata <= '0;
            pkt_o.tkeep <= '0;
            pkt_o.tstrb <= '0;
            pkt_o.tuser <= '0;
            pkt_o.tid   <= '0;
            pkt_o.tdest <= '0;
            pkt_o.tlast <= 1'b0;
        end else if (flush_req) begin
            pkt_o.tlast <= 1'b0;
        end else if (in_hs) begin
            if (ins_pos == '0) begin
                pkt_o.tdata <= '0;
                pkt_o.tkeep <= '0;
                pkt_o.tstrb <= '0;
                pkt_o.tuser <= pkt_i.tuser;
                pkt_o.tid   <= pkt_i.tid;
                pkt_o.tdest <= pkt_i.tdest;
            end else if (TUSER_MODE == TUSER_OR) begin
                pkt_o.tuser <= pkt_o.tuser | pkt_i.tuser;
            end
            pkt_o.tdata[lane_base*LANE_W +: LANE_W]     <= pkt_i.tdata;
            pkt_o.tkeep[lane_base*IN_BYTES +: IN_BYTES] <= pkt_i.tkeep;
            pkt_o.tstrb[lane_base*IN_BYTES +: IN_BYTES] <= pkt_i.tstrb;
            pkt_o.tlast <= pkt_i.tlast;
        end
    end

endmodule

// File: tb/tb_axi4_stream_upsize_gbx.sv
// Scoreboard bench for axi4_stream_upsize_gbx (IN_BYTES=2, RATIO=4).
// Two DUTs run in lockstep on identical stimulus: one TUSER_FIRST, one TUSER_OR.
module tb_axi4_stream_upsize_gbx;
    import axi4_stream_gbx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_BYTES(2)) in_if ();
    axi4_stream_if #(.DATA_BYTES(8)) out_if ();
    axi4_stream_if #(.DATA_BYTES(2)) in2 ();
    axi4_stream_if #(.DATA_BYTES(8)) out2 ();

    assign in2.tvalid  = in_if.tvalid;
    assign in2.tdata   = in_if.tdata;
    assign in2.tkeep   = in_if.tkeep;
    assign in2.tstrb   = in_if.tstrb;
    assign in2.tuser   = in_if.tuser;
    assign in2.tid     = in_if.tid;
    assign in2.tdest   = in_if.tdest;
    assign in2.tlast   = in_if.tlast;
    assign out2.tready = out_if.tready;

    axi4_stream_upsize_gbx #(
        .IN_BYTES(2), .RATIO(4), .TUSER_WIDTH(1), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_MODE(TUSER_FIRST)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(in_if), .pkt_o(out_if)
    );

    axi4_stream_upsize_gbx #(
        .IN_BYTES(2), .RATIO(4), .TUSER_WIDTH(1), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_MODE(TUSER_OR)
    ) dut_or (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(in2), .pkt_o(out2)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [7:0]  strb;
        logic        user_first;
        logic        user_or;
        logic        id;
        logic        dest;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                        input logic uf, input logic uo, input logic id, input logic last);
        exp_t e;
        e.data = d; e.keep = k; e.strb = s; e.user_first = uf; e.user_or = uo;
        e.id = id; e.dest = 1'b0; e.last = last;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: compare every output handshake with the next expected word.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_if.tvalid && out_if.tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no beat", out_if.tdata);
            end else begin
                e = sb.pop_front();
                check("out_tdata", out_if.tdata, e.data);
                check("out_tkeep", out_if.tkeep, e.keep);
                check("out_tstrb", out_if.tstrb, e.strb);
                check("out_tuser_first", out_if.tuser, e.user_first);
                check("out_tid", out_if.tid, e.id);
                check("out_tdest", out_if.tdest, e.dest);
                check("out_tlast", out_if.tlast, e.last);
                check("or_tvalid", out2.tvalid, 1);
                check("or_tdata", out2.tdata, e.data);
                check("out_tuser_or", out2.tuser, e.user_or);
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic [1:0] s,
                         input logic u, input logic id, input logic last, output int waits);
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = s;
        in_if.tuser  = u;
        in_if.tid    = id;
        in_if.tdest  = 1'b0;
        in_if.tlast  = last;
        in_if.tvalid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_if.tready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got tready 0 for %0d cycles expected acceptance", waits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] s, input logic u,
                        input logic id, input logic last);
        int w;
        drive(d, 2'b11, s, u, id, last, w);
    endtask

    task automatic idle();
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tstrb  = '0;
        in_if.tuser  = '0;
        in_if.tid    = '0;
        in_if.tdest  = '0;
        in_if.tlast  = 1'b0;
        out_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tdata", out_if.tdata, 0);
        check("rst_tkeep", out_if.tkeep, 0);
        check("rst_tlast", out_if.tlast, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back 8 beats, tlast on the 8th; tready must never drop.
        push(64'h0004_0003_0002_0001, 8'hFF, 8'hFF, 0, 0, 0, 0);
        push(64'h0008_0007_0006_0005, 8'hFF, 8'hFF, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            drive(16'(i), 2'b11, 2'b11, 1'b0, 1'b0, (i == 8), w);
            check("b2b_tready_wait", 64'(w), 0);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Short packet: zero-filled lane 3, tstrb independent of tkeep.
        push(64'h0000_CCCC_BBBB_AAAA, 8'h3F, 8'h37, 0, 0, 0, 1);
        send(16'hAAAA, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'hBBBB, 2'b01, 1'b0, 1'b0, 1'b0);
        send(16'hCCCC, 2'b11, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // tid change flushes the partial word with a single tready gap.
        push(64'h0000_0000_2222_1111, 8'h0F, 8'h0F, 0, 0, 0, 0);
        push(64'h0000_0000_0000_3333, 8'h03, 8'h03, 0, 0, 1, 1);
        send(16'h1111, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h2222, 2'b11, 1'b0, 1'b0, 1'b0);
        drive(16'h3333, 2'b11, 2'b11, 1'b0, 1'b1, 1'b1, w);
        check("flush_tready_gap", 64'(w), 1);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // tuser only on lane 2: FIRST gives 0, OR gives 1.
        push(64'h5A04_5A03_5A02_5A01, 8'hFF, 8'hFF, 0, 1, 0, 1);
        send(16'h5A01, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h5A02, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h5A03, 2'b11, 1'b1, 1'b0, 1'b0);
        send(16'h5A04, 2'b11, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Sink stall with a completed word and a pending input beat.
        out_if.tready = 1'b0;
        push(64'h0B04_0B03_0B02_0B01, 8'hFF, 8'hFF, 0, 0, 0, 0);
        push(64'h0B08_0B07_0B06_0B05, 8'hFF, 8'hFF, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) send(16'h0B00 + 16'(i), 2'b11, 1'b0, 1'b0, 1'b0);
        in_if.tdata  = 16'h0B05;
        in_if.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_tready", in_if.tready, 0);
            check("stall_tvalid", out_if.tvalid, 1);
            check("stall_tdata", out_if.tdata, 64'h0B04_0B03_0B02_0B01);
            check("stall_tlast", out_if.tlast, 0);
        end
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
        for (int i = 5; i <= 8; i++) send(16'h0B00 + 16'(i), 2'b11, 1'b0, 1'b0, (i == 8));
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-word discards the partial word.
        send(16'h0C01, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0C02, 2'b11, 1'b0, 1'b0, 1'b0);
        idle();
        check("partial_tdata", out_if.tdata, 64'h0000_0000_0C02_0C01);
        check("partial_tvalid", out_if.tvalid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tdata", out_if.tdata, 0);
        check("async_rst_tkeep", out_if.tkeep, 0);
        check("async_rst_tvalid", out_if.tvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(64'h0D04_0D03_0D02_0D01, 8'hFF, 8'hFF, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) send(16'h0D00 + 16'(i), 2'b11, 1'b0, 1'b0, (i == 4));
        idle();
        repeat (5) @(posedge clk);
        #1;

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
